// File: rtl/mem_wb_if.sv
// mem_wb_if: execute-to-memory handshake and payload bundle.
// The execute stage is the master; mem_wb is the slave.
interface mem_wb_if #(
  parameter int DWIDTH = 32
);
  logic              valid;
  logic              ready;
  logic [DWIDTH-1:0] alu_out;
  logic [DWIDTH-1:0] rs2;
  logic [2:0]        funct3;
  logic              mem_rd;
  logic              mem_we;
  logic              mem_to_reg;
  logic              reg_we;
  logic [4:0]        rd;

  modport master (
    output valid, alu_out, rs2, funct3,
    output mem_rd, mem_we, mem_to_reg,
    output reg_we, rd,
    input  ready
  );

  modport slave (
    input  valid, alu_out, rs2, funct3,
    input  mem_rd, mem_we, mem_to_reg,
    input  reg_we, rd,
    output ready
  );
endinterface

// File: rtl/mem_wb.sv
// mem_wb: memory access + writeback stage with load/store alignment.
// Optional MEM_WB_MISALIGN_TRAP_EN enables misalign detection.
module mem_wb #(
  parameter int DWIDTH      = 32,
  parameter int DMEM_AWIDTH = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hold,
  mem_wb_if.slave                ex,
  output logic [DMEM_AWIDTH-1:0] dmem_addr,
  output logic [DWIDTH-1:0]      dmem_din,
  output logic [3:0]             dmem_wbe,
  output logic                   dmem_en,
  input  logic [DWIDTH-1:0]      dmem_dout,
  output logic                   wb_valid,
  output logic                   wb_we,
  output logic [4:0]             wb_rd,
  output logic [DWIDTH-1:0]      wb_data,
  output logic                   misalign,
  output logic [DWIDTH-1:0]      misalign_addr
);

  logic              acc;
  logic              mem_op;
  logic              mis;
  logic [1:0]        sz;
  logic [1:0]        off_raw;
  logic [1:0]        off;
  logic [3:0]        st_wbe;
  logic [DWIDTH-1:0] st_din;

  logic              m_valid;
  logic [1:0]        m_off;
  logic [2:0]        m_f3;
  logic [4:0]        m_rd;
  logic              m_reg_we;
  logic              m_m2r;
  logic              m_mis;
  logic [DWIDTH-1:0] m_alu;

  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DWIDTH-1:0] ld_data;

  assign ex.ready = rst_n & ~hold;
  assign acc      = ex.valid & ex.ready;

  // Access geometry: size, byte offset and misalign flag.
  always_comb begin
    sz      = ex.funct3[1:0];
    off_raw = ex.alu_out[1:0];
    mem_op  = ex.mem_rd | ex.mem_we;
`ifdef MEM_WB_MISALIGN_TRAP_EN
    off = off_raw;
    mis = mem_op &
          (((sz == 2'b10) & (off_raw != 2'b00)) |
           ((sz == 2'b01) & off_raw[0]));
`else
    mis = 1'b0;
    off = off_raw;
    if (sz[1])
      off = 2'b00;
    else if (sz[0])
      off = {off_raw[1], 1'b0};
`endif
  end

  // Store lane replication and byte enables.
  always_comb begin
    st_wbe = 4'hF;
    st_din = ex.rs2;
    unique case (1'b1)
      sz == 2'b00: begin
        st_wbe = 4'b0001 << off;
        st_din = {(DWIDTH/8){ex.rs2[7:0]}};
      end
      sz == 2'b01: begin
        st_wbe = 4'b0011 << off;
        st_din = {(DWIDTH/16){ex.rs2[15:0]}};
      end
      default: begin
        st_wbe = 4'hF;
        st_din = ex.rs2;
      end
    endcase
  end

  // RAM port: new access on accept, re-read M's word on hold.
  always_comb begin
    dmem_addr = ex.alu_out[DMEM_AWIDTH+1:2];
    dmem_din  = st_din;
    dmem_wbe  = 4'h0;
    dmem_en   = 1'b0;
    if (!rst_n) begin
      dmem_en = 1'b0;
    end else if (hold) begin
      dmem_addr = m_alu[DMEM_AWIDTH+1:2];
      dmem_en   = 1'b1;
    end else if (acc & mem_op) begin
      dmem_en = 1'b1;
      if (ex.mem_we & ~mis)
        dmem_wbe = st_wbe;
    end
  end

  // M register: captures the accepted instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_off    <= 2'b00;
      m_f3     <= 3'b000;
      m_rd     <= 5'd0;
      m_reg_we <= 1'b0;
      m_m2r    <= 1'b0;
      m_mis    <= 1'b0;
      m_alu    <= '0;
    end else if (!hold) begin
      m_valid <= acc;
      if (acc) begin
        m_off    <= off;
        m_f3     <= ex.funct3;
        m_rd     <= ex.rd;
        m_reg_we <= ex.reg_we;
        m_m2r    <= ex.mem_to_reg;
        m_mis    <= mis;
        m_alu    <= ex.alu_out;
      end
    end
  end

  // Load lane select and extension for the M instruction.
  always_comb begin
    byte_v  = dmem_dout[{m_off, 3'b000} +: 8];
    half_v  = dmem_dout[{m_off[1], 4'b0000} +: 16];
    ld_data = dmem_dout;
    unique case (1'b1)
      m_f3[1:0] == 2'b00:
        ld_data = m_f3[2] ?
          {{(DWIDTH-8){1'b0}}, byte_v} :
          {{(DWIDTH-8){byte_v[7]}}, byte_v};
      m_f3[1:0] == 2'b01:
        ld_data = m_f3[2] ?
          {{(DWIDTH-16){1'b0}}, half_v} :
          {{(DWIDTH-16){half_v[15]}}, half_v};
      default:
        ld_data = dmem_dout;
    endcase
  end

  // WB register: retires M on every unstalled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= '0;
    end else if (!hold) begin
      wb_valid <= m_valid;
      wb_we    <= m_valid & m_reg_we & ~m_mis &
                  (m_rd != 5'd0);
      wb_rd    <= m_rd;
      wb_data  <= m_m2r ? ld_data : m_alu;
    end
  end

`ifdef MEM_WB_MISALIGN_TRAP_EN
  // Misalign report: single pulse, cleared on held edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else if (!hold) begin
      misalign      <= m_valid & m_mis;
      misalign_addr <= (m_valid & m_mis) ? m_alu : '0;
    end else begin
      misalign <= 1'b0;
    end
  end
`else
  assign misalign      = 1'b0;
  assign misalign_addr = '0;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: random + directed bench for mem_wb.
// Reference model works per instruction on a word-addressed memory map.
module tb_mem_wb;
  localparam int DW = 32;
  localparam int AW = 14;

  typedef struct {
    bit          v;
    bit          mrd;
    bit          mwe;
    bit          m2r;
    bit          rwe;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } inst_t;

  typedef struct {
    bit          v;
    bit          we;
    bit          mis;
    bit          bad;
    bit          pulse;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] alu;
    logic [31:0] maddr;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  always #5 clk = ~clk;

  mem_wb_if #(.DWIDTH(DW)) exb ();

  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_din;
  logic [31:0]   dmem_dout;
  logic [3:0]    dmem_wbe;
  logic          dmem_en;
  logic          wb_valid;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          misalign;
  logic [31:0]   misalign_addr;

  mem_wb #(.DWIDTH(DW), .DMEM_AWIDTH(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hold          (hold),
    .ex            (exb),
    .dmem_addr     (dmem_addr),
    .dmem_din      (dmem_din),
    .dmem_wbe      (dmem_wbe),
    .dmem_en       (dmem_en),
    .dmem_dout     (dmem_dout),
    .wb_valid      (wb_valid),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .misalign      (misalign),
    .misalign_addr (misalign_addr)
  );

  logic [31:0] ram [0:(1<<AW)-1];
  logic [31:0] ram_nw;

  always_comb begin
    ram_nw = ram[dmem_addr];
    for (int b = 0; b < 4; b++)
      if (dmem_wbe[b]) ram_nw[8*b +: 8] = dmem_din[8*b +: 8];
  end

  always @(posedge clk)
    if (dmem_en) begin
      ram[dmem_addr] <= ram_nw;
      dmem_dout      <= ram_nw;
    end

  int n_tests;
  int n_fail;
  bit chk_on = 1'b0;

  logic [31:0] arch [int];
  slot_t cm, cw;
  bit    p_r, p_h;
  inst_t p_i;

  bit          e_ready, e_en;
  logic [3:0]  e_wbe;
  logic [13:0] e_addr;
  logic [31:0] e_din;

  function automatic void chk(input string nm,
                              input logic [31:0] a,
                              input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, a, e, $time);
    end
  endfunction

  function automatic void geom(input inst_t i, output int nb,
                               output int off, output bit mis);
    nb  = (i.f3[1:0] == 2'b00) ? 1 :
          (i.f3[1:0] == 2'b01) ? 2 : 4;
    off = int'(i.alu[1:0]);
    mis = 1'b0;
`ifdef MEM_WB_MISALIGN_TRAP_EN
    mis = (i.mrd || i.mwe) && (off % nb != 0);
`else
    off = off - (off % nb);
`endif
  endfunction

  function automatic slot_t exec(input inst_t i);
    int nb, off, w;
    bit mis;
    logic [31:0] word, val;
    slot_t s;
    geom(i, nb, off, mis);
    w = int'(i.alu[15:2]);
    word = arch.exists(w) ? arch[w] : 32'h0;
    if (i.mwe && !mis) begin
      for (int k = 0; k < nb; k++)
        word[8*(off+k) +: 8] = i.rs2[8*k +: 8];
      arch[w] = word;
    end
    val = word >> (8*off);
    if (nb == 1)
      val = i.f3[2] ? {24'h0, val[7:0]} :
                      {{24{val[7]}}, val[7:0]};
    else if (nb == 2)
      val = i.f3[2] ? {16'h0, val[15:0]} :
                      {{16{val[15]}}, val[15:0]};
    s = '{default: 0};
    s.v    = 1'b1;
    s.mis  = mis;
    s.we   = i.rwe && !mis && (i.rd != 5'd0);
    s.rd   = i.rd;
    s.data = i.m2r ? val : i.alu;
    s.alu  = i.alu;
    return s;
  endfunction

  function automatic inst_t mk(input int kind,
                               input logic [2:0] f3,
                               input logic [31:0] a,
                               input logic [31:0] d,
                               input logic [4:0] rd);
    inst_t i;
    i.v   = (kind != 0);
    i.mrd = (kind == 1);
    i.mwe = (kind == 2);
    i.m2r = (kind == 1);
    i.rwe = (kind == 1) || (kind == 3);
    i.f3  = f3;
    i.alu = a;
    i.rs2 = d;
    i.rd  = rd;
    return i;
  endfunction

  task automatic set_exp(input inst_t i, input bit r, input bit h);
    int nb, off;
    bit mis;
    e_ready = r && !h;
    e_en    = 1'b0;
    e_wbe   = 4'h0;
    e_addr  = i.alu[15:2];
    e_din   = 32'h0;
    if (r && h) begin
      e_en   = 1'b1;
      e_addr = cm.alu[15:2];
    end else if (r && i.v && (i.mrd || i.mwe)) begin
      e_en = 1'b1;
      geom(i, nb, off, mis);
      if (i.mwe && !mis) begin
        e_wbe = 4'(((1 << nb) - 1) << off);
        for (int j = 0; j < 4; j++)
          e_din[8*j +: 8] = i.rs2[8*(j % nb) +: 8];
      end
    end
  endtask

  task automatic tick(input bit r, input bit h, input inst_t i);
    @(posedge clk);
    #1;
    if (p_r) begin
      if (p_h) begin
        cw.pulse = 1'b0;
      end else begin
        cw.v     = cm.v;
        cw.we    = cm.v && cm.we;
        cw.bad   = cm.v && cm.mis;
        cw.pulse = cw.bad;
        cw.rd    = cm.rd;
        cw.data  = cm.data;
        cw.maddr = cw.bad ? cm.alu : 32'h0;
        if (p_i.v) cm = exec(p_i);
        else       cm.v = 1'b0;
      end
    end
    rst_n          = r;
    hold           = h;
    exb.valid      = i.v;
    exb.mem_rd     = i.mrd;
    exb.mem_we     = i.mwe;
    exb.mem_to_reg = i.m2r;
    exb.reg_we     = i.rwe;
    exb.funct3     = i.f3;
    exb.alu_out    = i.alu;
    exb.rs2        = i.rs2;
    exb.rd         = i.rd;
    if (!r) begin
      cm = '{default: 0};
      cw = '{default: 0};
    end
    p_r = r;
    p_h = h;
    p_i = i;
    set_exp(i, r, h);
  endtask

  always @(negedge clk)
    if (chk_on) begin
      chk("ex_ready", 32'(exb.ready), 32'(e_ready));
      chk("dmem_en", 32'(dmem_en), 32'(e_en));
      chk("dmem_wbe", 32'(dmem_wbe), 32'(e_wbe));
      if (e_en) chk("dmem_addr", 32'(dmem_addr), 32'(e_addr));
      if (e_wbe != 0) chk("dmem_din", dmem_din, e_din);
      chk("wb_valid", 32'(wb_valid), 32'(cw.v));
      chk("wb_we", 32'(wb_we), 32'(cw.we));
      if (cw.v) chk("wb_rd", 32'(wb_rd), 32'(cw.rd));
      if (cw.v && !cw.bad) chk("wb_data", wb_data, cw.data);
      chk("misalign", 32'(misalign), 32'(cw.pulse));
      chk("misalign_addr", misalign_addr, cw.maddr);
    end

  task automatic run_random();
    logic [2:0] lf [5];
    inst_t i;
    int k;
    bit r, h;
    logic [31:0] a;
    lf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int c = 0; c < 3000; c++) begin
      k = int'($urandom_range(0, 9));
      a = ($urandom() & 32'hFFFF_0000) |
          (32'h100 + 32'($urandom_range(0, 31)));
      if (k < 2)
        i = mk(0, 3'b000, a, $urandom(), 5'd0);
      else if (k < 5)
        i = mk(1, lf[$urandom_range(0, 4)], a, $urandom(),
               5'($urandom_range(0, 31)));
      else if (k < 8)
        i = mk(2, 3'($urandom_range(0, 2)), a, $urandom(),
               5'($urandom_range(0, 31)));
      else begin
        i = mk(3, 3'b000, $urandom(), $urandom(),
               5'($urandom_range(0, 31)));
        i.rwe = $urandom_range(0, 1) == 1;
      end
      h = $urandom_range(0, 99) < 15;
      r = $urandom_range(0, 99) >= 1;
      tick(r, h, i);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1);
  end

  initial begin
    inst_t nop;
    n_tests = 0;
    n_fail  = 0;
    nop = mk(0, 3'b000, 32'h0, 32'h0, 5'd0);
    cm  = '{default: 0};
    cw  = '{default: 0};
    p_r = 1'b0;
    p_h = 1'b0;
    p_i = nop;
    exb.valid      = 1'b0;
    exb.mem_rd     = 1'b0;
    exb.mem_we     = 1'b0;
    exb.mem_to_reg = 1'b0;
    exb.reg_we     = 1'b0;
    exb.funct3     = 3'b000;
    exb.alu_out    = 32'h0;
    exb.rs2        = 32'h0;
    exb.rd         = 5'd0;
    set_exp(nop, 1'b0, 1'b0);
    chk_on = 1'b1;
    repeat (3) tick(1'b0, 1'b0, nop);
    tick(1'b1, 1'b0, nop);
    @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);

    tick(1'b1, 1'b0, mk(2, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0));
    @(negedge clk);
    chk("sw_wbe", 32'(dmem_wbe), 32'hF);
    tick(1'b1, 1'b0, mk(1, 3'b010, 32'h100, 32'h0, 5'd5));
    tick(1'b1, 1'b0, nop);
    tick(1'b1, 1'b0, nop);
    @(negedge clk);
    chk("lw_we", 32'(wb_we), 32'h1);
    chk("lw_rd", 32'(wb_rd), 32'h5);
    chk("lw_data", wb_data, 32'hDEADBEEF);

    tick(1'b1, 1'b0, mk(2, 3'b000, 32'h103, 32'h80, 5'd0));
    @(negedge clk);
    chk("sb_wbe", 32'(dmem_wbe), 32'h8);
    tick(1'b1, 1'b0, mk(1, 3'b000, 32'h103, 32'h0, 5'd6));
    tick(1'b1, 1'b0, mk(1, 3'b100, 32'h103, 32'h0, 5'd7));
    tick(1'b1, 1'b0, nop);
    @(negedge clk);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    tick(1'b1, 1'b0, nop);
    @(negedge clk);
    chk("lbu_data", wb_data, 32'h00000080);

    tick(1'b1, 1'b0, mk(2, 3'b001, 32'h102, 32'h8001, 5'd0));
    @(negedge clk);
    chk("sh_wbe", 32'(dmem_wbe), 32'hC);
    tick(1'b1, 1'b0, mk(1, 3'b001, 32'h102, 32'h0, 5'd6));
    tick(1'b1, 1'b0, mk(1, 3'b101, 32'h102, 32'h0, 5'd7));
    tick(1'b1, 1'b0, nop);
    @(negedge clk);
    chk("lh_data", wb_data, 32'hFFFF8001);
    tick(1'b1, 1'b0, nop);
    @(negedge clk);
    chk("lhu_data", wb_data, 32'h00008001);

    tick(1'b1, 1'b0, mk(1, 3'b010, 32'h101, 32'h0, 5'd10));
    @(negedge clk);
    chk("lw101_wbe", 32'(dmem_wbe), 32'h0);
    tick(1'b1, 1'b0, nop);
    tick(1'b1, 1'b0, nop);
    @(negedge clk);
`ifdef MEM_WB_MISALIGN_TRAP_EN
    chk("mis_we", 32'(wb_we), 32'h0);
    chk("mis_pulse", 32'(misalign), 32'h1);
    chk("mis_addr", misalign_addr, 32'h101);
`else
    chk("lw101_data", wb_data, 32'h8001BEEF);
    chk("lw101_mis", 32'(misalign), 32'h0);
`endif

    tick(1'b1, 1'b0, mk(1, 3'b010, 32'h100, 32'h0, 5'd9));
    repeat (3) begin
      tick(1'b1, 1'b1, mk(2, 3'b010, 32'h100, 32'h11111111, 5'd0));
      @(negedge clk);
      chk("hold_ready", 32'(exb.ready), 32'h0);
    end
    tick(1'b1, 1'b0, nop);
    tick(1'b1, 1'b0, nop);
    @(negedge clk);
    chk("hold_rd", 32'(wb_rd), 32'd9);
    chk("hold_data", wb_data, 32'h8001BEEF);

    tick(1'b1, 1'b0, mk(3, 3'b000, 32'h1234, 32'h0, 5'd3));
    tick(1'b1, 1'b0, nop);
    tick(1'b0, 1'b0, mk(2, 3'b010, 32'h100, 32'h22222222, 5'd0));
    @(negedge clk);
    chk("rst_valid", 32'(wb_valid), 32'h0);
    chk("rst_data", wb_data, 32'h0);
    chk("rst_en", 32'(dmem_en), 32'h0);
    tick(1'b0, 1'b0, nop);
    tick(1'b1, 1'b0, mk(1, 3'b010, 32'h100, 32'h0, 5'd11));
    tick(1'b1, 1'b0, nop);
    tick(1'b1, 1'b0, nop);
    @(negedge clk);
    chk("rst_ram", ram[64], 32'h8001BEEF);
    chk("rst_ld", wb_data, 32'h8001BEEF);

    run_random();
    tick(1'b1, 1'b0, nop);
    tick(1'b1, 1'b0, nop);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_wb.md
# mem_wb

Memory-access and writeback stage of the RISC-V core, directly downstream of the execute stage. Takes the execute stage's ALU result, store data, funct3 and memory/writeback controls. Drives the byte-write-enable synchronous data RAM with correctly aligned store data and byte enables. Sign- or zero-extends and aligns load data (lb/lh/lw/lbu/lhu), and presents a registered writeback to the register file two cycles after acceptance.

## Interface
- DWIDTH, 32, datapath width.
- DMEM_AWIDTH, 14, data RAM word-address width.

- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- hold  input  1  hazard-unit freeze; stalls the stage.
- ex_valid  input  1  execute stage presents an instruction.
- ex_ready  output  1  stage accepts; equals !hold while rst_n=1, else 0.
- ex_alu_out  input  DWIDTH  effective address or ALU result.
- ex_rs2  input  DWIDTH  store data.
- ex_funct3  input  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
- ex_mem_rd, ex_mem_we, ex_mem_to_reg, ex_reg_we  input  1 each  load, store, select load data, write rd.
- ex_rd  input  5  destination register.
- dmem_addr  output  DMEM_AWIDTH  word address.
- dmem_din  output  DWIDTH  write data.
- dmem_wbe  output  4  byte write enables.
- dmem_en  output  1  RAM enable.
- dmem_dout  input  DWIDTH  RAM read data, valid one cycle after enable.
- wb_valid  output  1  writeback slot valid.
- wb_we  output  1  register-file write enable.
- wb_rd  output  5  register-file address.
- wb_data  output  DWIDTH  register-file write data.
- misalign  output  1  one-cycle pulse, misaligned access retired.
- misalign_addr  output  DWIDTH  offending effective address.

## Operation
- Accept: `ex_valid && ex_ready`. dmem is driven combinationally in the accept cycle:
  - `dmem_addr = ex_alu_out[DMEM_AWIDTH+1:2]`; upper address bits are ignored.
  - `dmem_en = 1` for loads and stores.
- Store data and enables, with off = `ex_alu_out[1:0]`:
  - sb: `dmem_wbe = 4'b0001 << off`; `dmem_din` = `ex_rs2[7:0]` replicated ×4.
  - sh: `dmem_wbe = 4'b0011 << off`; `dmem_din` = `ex_rs2[15:0]` replicated ×2.
  - sw: `dmem_wbe = 4'hF`; `dmem_din = ex_rs2`.
  - Loads and non-memory ops drive `wbe = 0`.
- M register, captured on accept: valid, off, funct3, rd, reg_we, mem_to_reg, ALU result, misalign flag, address.
  - If not accepted, M valid clears, unless hold=1.
- Load alignment, applied to the M-register instruction:
  - Byte = `dmem_dout[8*off +: 8]`; half = `dmem_dout[16*off[1] +: 16]`.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- WB register, loaded from M each unstalled edge:
  - `wb_valid` = M valid.
  - `wb_we` = M valid & reg_we & !misalign & (rd≠0).
  - `wb_data` = aligned load data if mem_to_reg, else the ALU result.
- Hold: ex_ready=0, and M and WB registers keep their values.
  - dmem is re-driven with M's address, en=1, wbe=0, so `dmem_dout` stays valid for the held load.
  - Stores are never re-issued.
- Misalign: lw with off≠0; lh/lhu/sh with off[0]=1.
  - Store is suppressed (`wbe = 0`) and no register write occurs.
  - At WB: `misalign = 1` for one cycle, `misalign_addr` = effective address.

## Timing
- Latency: accept at cycle T; `wb_*` valid after edge T+2, for every instruction type.
- Throughput: one instruction per cycle when hold=0.
- Store commits at edge T+1.
- Reset: rst_n low asynchronously clears M valid and all WB outputs.
  - `wb_valid`, `wb_we`, `wb_rd`, `wb_data`, `misalign`, `misalign_addr` = 0.
  - `dmem_en`, `dmem_wbe` forced to 0 while rst_n=0.
  - In-flight instructions are dropped, and no store is issued during reset.
- Hold on the same edge as accept: hold wins and nothing is accepted.
- Back-to-back store then load to the same word: the load observes the stored data; the RAM is write-first.

## Configuration
- `MEM_WB_MISALIGN_TRAP_EN` defined: misalign detection, suppression and the `misalign`/`misalign_addr` outputs behave as described.
- Undefined:
  - off is truncated to natural alignment (halfword: off[0] forced 0; word: off forced 0), and the access proceeds.
  - `misalign` and `misalign_addr` are tied to 0.

## Test plan
- sw 0xDEADBEEF at addr 0x100, then lw 0x100 rd=5 -> `dmem_wbe = F`; `wb_we = 1`, `wb_rd = 5`, `wb_data = 0xDEADBEEF` two cycles after the load's accept.
- sb 0x80 at 0x103; lb and lbu 0x103 -> `wbe = 1000`; lb gives 0xFFFFFF80, lbu gives 0x00000080.
- sh 0x8001 at 0x102; lh and lhu 0x102 -> `wbe = 1100`; 0xFFFF8001 and 0x00008001.
- lw at 0x101 with macro defined -> `wbe = 0`, `wb_we = 0`, `misalign` pulse, `misalign_addr = 0x101`; without the macro, word 0x100 is read.
- Load accepted, then hold for 3 cycles -> `ex_ready = 0`, WB outputs unchanged, and the correct load data appears after hold drops.
- rst_n low mid-stream with a store accepted in the same cycle -> WB outputs 0 immediately, `dmem_en = 0`, and the memory location is unchanged.
